// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
//
// Purpose: computes quotient (lo) and remainder (hi) for signed or unsigned
// division, one quotient bit per cycle, stalling the pipeline while it runs.
//
// Ports:
//   clk          core clock
//   rst          synchronous, active-high reset
//   start        EX holds a divide; level, held while stalled
//   signed_div   1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
//   annul        flush/exception, kills any in-flight divide
//   a, b         dividend / divisor; sampled with start
//   stall        hold IF..EX while the divide is not yet complete
//   result_valid one-cycle pulse, hi/lo carry a fresh result
//   hi, lo       remainder / quotient

module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              stall,
  output logic              result_valid,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rem;
  logic [DATA_W-1:0]  quo;   // holds the dividend, shifted out as quotient bits shift in
  logic [DATA_W-1:0]  dvsr;
  logic               neg_q;
  logic               neg_r;
  logic               div_zero;

  logic [DATA_W-1:0]  abs_a;
  logic [DATA_W-1:0]  abs_b;
  logic [DATA_W:0]    rem_shift;
  logic [DATA_W:0]    diff;
  logic               q_bit;
  logic [DATA_W-1:0]  rem_nxt;
  logic [DATA_W-1:0]  quo_nxt;
  logic [DATA_W-1:0]  lo_fin;
  logic [DATA_W-1:0]  hi_fin;
  logic               last_iter;

  always_comb begin
    abs_a = (signed_div && a[DATA_W-1]) ? -a : a;
    abs_b = (signed_div && b[DATA_W-1]) ? -b : b;

    // rem < dvsr always holds, so the shifted partial remainder fits in
    // DATA_W+1 bits and the sign of diff decides the quotient bit.
    rem_shift = {rem, quo[DATA_W-1]};
    diff      = rem_shift - {1'b0, dvsr};
    q_bit     = ~diff[DATA_W];
    rem_nxt   = q_bit ? diff[DATA_W-1:0] : rem_shift[DATA_W-1:0];
    quo_nxt   = {quo[DATA_W-2:0], q_bit};

    // A zero divisor naturally yields all-ones / |a|; restoring the dividend
    // sign on the remainder gives back a unchanged, so only lo is forced.
    lo_fin    = div_zero ? {DATA_W{1'b1}} : (neg_q ? -quo_nxt : quo_nxt);
    hi_fin    = neg_r ? -rem_nxt : rem_nxt;

    last_iter = (cnt == CNT_W'(DATA_W - 1));
  end

  assign stall = ~rst & ~annul & (((state == IDLE) & start) | (state == BUSY));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      dvsr         <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      div_zero     <= 1'b0;
      hi           <= '0;
      lo           <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !annul) begin
            rem      <= '0;
            quo      <= abs_a;
            dvsr     <= abs_b;
            neg_q    <= signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
            neg_r    <= signed_div & a[DATA_W-1];
            div_zero <= (b == '0);
            cnt      <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (annul) begin
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + CNT_W'(1);
            // Results are registered on the final iteration so they are
            // visible during the DONE cycle alongside result_valid.
            if (last_iter) begin
              hi           <= hi_fin;
              lo           <= lo_fin;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end
        end
        DONE: begin
          // The finished instruction is still in EX; start is ignored here.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit

module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  div_unit #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_div   (signed_div),
    .annul        (annul),
    .a            (a),
    .b            (b),
    .stall        (stall),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference arithmetic straight from the division rules.
  function automatic void ref_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] q, output logic [31:0] r);
    if (y == 32'h0) begin
      q = 32'hFFFFFFFF;
      r = x;
    end else if (sgn) begin
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
        q = x;
        r = 32'h0;
      end else begin
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
      end
    end else begin
      q = x / y;
      r = x % y;
    end
  endfunction

  // Transaction-level model: an accepted divide started at cycle t0 keeps the
  // pipeline stalled through t0+32 and reports its result at t0+33.
  bit          pending = 1'b0;
  int          t0 = 0;
  logic [31:0] p_hi, p_lo;
  logic [31:0] cur_hi = 32'h0;
  logic [31:0] cur_lo = 32'h0;

  initial begin
    int   age;
    bit   inflight;
    bit   done;
    logic e_stall;
    @(posedge clk);
    forever begin
      @(negedge clk);
      age      = cyc - t0;
      inflight = pending && age >= 1 && age <= 32;
      done     = pending && age == 33;
      e_stall  = rst ? 1'b0 : (~annul & ((~pending & start) | inflight));
      if (done) begin
        cur_hi = p_hi;
        cur_lo = p_lo;
      end
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("result_valid", {31'b0, result_valid}, {31'b0, done});
      chk("hi", hi, cur_hi);
      chk("lo", lo, cur_lo);
      if (rst) begin
        pending = 1'b0;
        cur_hi  = 32'h0;
        cur_lo  = 32'h0;
      end else if (annul || done) begin
        pending = 1'b0;
      end else if (!pending && start) begin
        pending = 1'b1;
        t0      = cyc;
        ref_div(signed_div, a, b, p_lo, p_hi);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds start until the result pulse; returns at the cycle after DONE.
  task automatic run_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int nstall, output int vcyc);
    start      = 1'b1;
    signed_div = sgn;
    a          = x;
    b          = y;
    lat        = -1;
    nstall     = 0;
    vcyc       = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid) begin
        lat  = i;
        vcyc = cyc;
        break;
      end
      if (stall) nstall++;
    end
    if (lat < 0) chk("result_valid_timeout", {31'b0, result_valid}, 32'h1);
    step();
  endtask

  task automatic div_lit(input string nm, input logic sgn, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] e_lo, input logic [31:0] e_hi);
    int lat, ns, vc;
    run_div(sgn, x, y, lat, ns, vc);
    start = 1'b0;
    chk({nm, "_lo"}, lo, e_lo);
    chk({nm, "_hi"}, hi, e_hi);
    chk({nm, "_latency"}, lat, 33);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, ns, vc1, vc2;
    rst        = 1'b1;
    start      = 1'b0;
    signed_div = 1'b0;
    annul      = 1'b0;
    a          = 32'h0;
    b          = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_stall", {31'b0, stall}, 32'h0);
    chk("reset_valid", {31'b0, result_valid}, 32'h0);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    step();

    // First divide: latency and stall length.
    run_div(1'b0, 32'd100, 32'd7, lat, ns, vc1);
    start = 1'b0;
    chk("divu100_7_lo", lo, 32'd14);
    chk("divu100_7_hi", hi, 32'd2);
    chk("divu100_7_latency", lat, 33);
    chk("divu100_7_stall_cycles", ns, 33);
    step();

    div_lit("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF);
    div_lit("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
    div_lit("div_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0);
    div_lit("divu_5_0",     1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5);
    div_lit("div_m5_0",     1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB);
    div_lit("div_m100_m7",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE);
    div_lit("divu_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'h0);
    div_lit("divu_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'h0);
    div_lit("divu_3_9",     1'b0, 32'd3,        32'd9,        32'd0,        32'd3);

    // Annul mid-divide after a known result.
    div_lit("pre_annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    start      = 1'b1;
    signed_div = 1'b0;
    a          = 32'd1000;
    b          = 32'd3;
    repeat (10) step();
    annul = 1'b1;
    @(negedge clk);
    chk("annul_stall", {31'b0, stall}, 32'h0);
    step();
    annul = 1'b0;
    start = 1'b0;
    repeat (40) step();
    chk("annul_hi_kept", hi, 32'd2);
    chk("annul_lo_kept", lo, 32'd14);

    // Back-to-back divides with start held across DONE.
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, ns, vc1);
    chk("b2b_first_lo", lo, 32'hFFFFFFFD);
    chk("b2b_first_hi", hi, 32'hFFFFFFFF);
    run_div(1'b0, 32'd100, 32'd7, lat, ns, vc2);
    start = 1'b0;
    chk("b2b_second_lo", lo, 32'd14);
    chk("b2b_second_hi", hi, 32'd2);
    chk("b2b_spacing", vc2 - vc1, 34);
    step();

    // Reset in the middle of a divide.
    start      = 1'b1;
    signed_div = 1'b1;
    a          = 32'd1000;
    b          = 32'hFFFFFFFD;
    repeat (5) step();
    rst   = 1'b1;
    start = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_stall", {31'b0, stall}, 32'h0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    step();
    repeat (40) step();
    div_lit("after_rst", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
